// File: rtl/rate_limiter_multi_regs.sv
// Per-queue register block for the multi-queue rate limiter, living on the UDP register ring.
// Holds a per-queue enable bit and throughput shift, plus saturating, write-to-clear
// packet-sent and stall-cycle counters.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef RATE_LIMIT_0_BLOCK_ADDR
`define RATE_LIMIT_0_BLOCK_ADDR 17'h0_0180
`endif

module rate_limiter_multi_regs #(
  parameter int unsigned UDP_REG_SRC_WIDTH = 2,
  parameter int unsigned NUM_QUEUES        = 4,
  parameter int unsigned SHIFT_WIDTH       = 4,
  parameter int unsigned REG_ADDR_WIDTH    = 6,
  parameter logic [`UDP_REG_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] BLOCK_TAG = `RATE_LIMIT_0_BLOCK_ADDR
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  reg_req_in,
  input  logic                                  reg_ack_in,
  input  logic                                  reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]        reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]       reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_in,
  output logic                                  reg_req_out,
  output logic                                  reg_ack_out,
  output logic                                  reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]        reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]       reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_out,
  input  logic [NUM_QUEUES-1:0]                 pkt_sent,
  input  logic [NUM_QUEUES-1:0]                 stall,
  output logic [NUM_QUEUES-1:0]                 enable_rate_limit,
  output logic [NUM_QUEUES*SHIFT_WIDTH-1:0]     thruput_shift
);

  localparam int unsigned ADDR_W = `UDP_REG_ADDR_WIDTH;
  localparam int unsigned DATA_W = `CPCI_NF2_DATA_WIDTH;
  localparam int unsigned QSEL_W = REG_ADDR_WIDTH - 2;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] SUB_ENABLE = 2'd0;
  localparam logic [1:0] SUB_SHIFT  = 2'd1;
  localparam logic [1:0] SUB_PKT    = 2'd2;
  localparam logic [1:0] SUB_STALL  = 2'd3;

  logic                                   req_q, req_d;
  logic                                   ack_q, ack_d;
  logic [DATA_W-1:0]                      data_q, data_d;
  logic                                   rd_wr_L_q;
  logic [ADDR_W-1:0]                      addr_q;
  logic [UDP_REG_SRC_WIDTH-1:0]           src_q;

  logic [NUM_QUEUES-1:0]                  en_q, en_d;
  logic [NUM_QUEUES-1:0][SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [NUM_QUEUES-1:0][CNT_W-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [NUM_QUEUES-1:0][CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic [QSEL_W-1:0]                      q_idx;
  logic [1:0]                             sub;
  logic                                   tag_hit;
  logic                                   addr_good;
  logic [DATA_W-1:0]                      rd_data;

  assign q_idx     = reg_addr_in[REG_ADDR_WIDTH-1:2];
  assign sub       = reg_addr_in[1:0];
  assign tag_hit   = (reg_addr_in[ADDR_W-1:REG_ADDR_WIDTH] == BLOCK_TAG);
  assign addr_good = (32'(q_idx) < NUM_QUEUES);

  // Ring response, register writes/clears and saturating counter updates.
  always_comb begin
    req_d       = reg_req_in;
    ack_d       = reg_ack_in;
    data_d      = reg_data_in;
    en_d        = en_q;
    shift_d     = shift_q;
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    rd_data     = '0;

    for (int i = 0; i < int'(NUM_QUEUES); i++) begin
      if (q_idx == QSEL_W'(i)) begin
        case (sub)
          SUB_ENABLE: rd_data = DATA_W'(en_q[i]);
          SUB_SHIFT:  rd_data = DATA_W'(shift_q[i]);
          SUB_PKT:    rd_data = DATA_W'(pkt_cnt_q[i]);
          default:    rd_data = DATA_W'(stall_cnt_q[i]);
        endcase
      end
    end

    for (int i = 0; i < int'(NUM_QUEUES); i++) begin
      if (pkt_sent[i] && (pkt_cnt_q[i] != '1)) pkt_cnt_d[i] = pkt_cnt_q[i] + CNT_W'(1);
      if (stall[i] && (stall_cnt_q[i] != '1))  stall_cnt_d[i] = stall_cnt_q[i] + CNT_W'(1);
    end

    if (reg_req_in && tag_hit) begin
      ack_d  = 1'b1;
      data_d = addr_good ? rd_data : DATA_W'(32'hdead_beef);
      if (addr_good && !reg_rd_wr_L_in) begin
        for (int i = 0; i < int'(NUM_QUEUES); i++) begin
          if (q_idx == QSEL_W'(i)) begin
            case (sub)
              SUB_ENABLE: en_d[i]        = reg_data_in[0];
              SUB_SHIFT:  shift_d[i]     = reg_data_in[SHIFT_WIDTH-1:0];
              // a clear coinciding with an event leaves the count at that single event
              SUB_PKT:    pkt_cnt_d[i]   = CNT_W'(pkt_sent[i]);
              default:    stall_cnt_d[i] = CNT_W'(stall[i]);
            endcase
          end
        end
      end
    end
  end

  // Resettable state: ring handshake and all per-queue registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      data_q      <= '0;
      en_q        <= '0;
      shift_q     <= '0;
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      req_q       <= req_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      en_q        <= en_d;
      shift_q     <= shift_d;
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Ring fields that simply ride along one cycle behind, with no reset.
  always_ff @(posedge clk) begin
    rd_wr_L_q <= reg_rd_wr_L_in;
    addr_q    <= reg_addr_in;
    src_q     <= reg_src_in;
  end

  assign reg_req_out       = req_q;
  assign reg_ack_out       = ack_q;
  assign reg_data_out      = data_q;
  assign reg_rd_wr_L_out   = rd_wr_L_q;
  assign reg_addr_out      = addr_q;
  assign reg_src_out       = src_q;
  assign enable_rate_limit = en_q;
  assign thruput_shift     = shift_q;

endmodule

// File: tb/tb_rate_limiter_multi_regs.sv
// Scoreboard bench for rate_limiter_multi_regs: a driver issues directed and random ring
// traffic plus counter events, a behavioural model predicts responses into queues, and a
// monitor pops and compares whatever the DUT presents each cycle.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_rate_limiter_multi_regs;

  localparam int unsigned AW   = `UDP_REG_ADDR_WIDTH;
  localparam int unsigned DW   = `CPCI_NF2_DATA_WIDTH;
  localparam int unsigned SRCW = 2;
  localparam int unsigned NQ   = 4;
  localparam int unsigned SW   = 4;
  localparam int unsigned RAW  = 6;
  localparam int unsigned TAGW = AW - RAW;
  localparam int unsigned QW   = RAW - 2;
  localparam logic [TAGW-1:0] TAG = TAGW'(17'h0_1a5c);

  logic              clk = 1'b0;
  logic              reset;
  logic              reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0]     reg_addr_in;
  logic [DW-1:0]     reg_data_in;
  logic [SRCW-1:0]   reg_src_in;
  logic              reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0]     reg_addr_out;
  logic [DW-1:0]     reg_data_out;
  logic [SRCW-1:0]   reg_src_out;
  logic [NQ-1:0]     pkt_sent, stall;
  logic [NQ-1:0]     enable_rate_limit;
  logic [NQ*SW-1:0]  thruput_shift;

  rate_limiter_multi_regs #(
    .UDP_REG_SRC_WIDTH(SRCW), .NUM_QUEUES(NQ), .SHIFT_WIDTH(SW),
    .REG_ADDR_WIDTH(RAW), .BLOCK_TAG(TAG)
  ) dut (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .pkt_sent(pkt_sent), .stall(stall),
    .enable_rate_limit(enable_rate_limit), .thruput_shift(thruput_shift)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            ack;
    logic [DW-1:0]   data;
    logic [AW-1:0]   addr;
    logic [SRCW-1:0] src;
    logic            rw;
  } ring_t;

  typedef struct {
    logic             req;
    logic             rst;
    logic [NQ-1:0]    en;
    logic [NQ*SW-1:0] sh;
  } st_t;

  ring_t ring_q[$];
  st_t   st_q[$];

  // Behavioural model of the architectural registers.
  logic          en_m [NQ];
  logic [SW-1:0] sh_m [NQ];
  logic [31:0]   pk_m [NQ];
  logic [31:0]   sl_m [NQ];

  int total = 0;
  int bad   = 0;
  logic checking = 1'b0;
  logic release_pending = 1'b0;
  logic [NQ-1:0][31:0] force_val;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v, input logic inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  function automatic logic [31:0] rd_val(input int q, input int sub);
    case (sub)
      0:       return 32'(en_m[q]);
      1:       return 32'(sh_m[q]);
      2:       return pk_m[q];
      default: return sl_m[q];
    endcase
  endfunction

  function automatic logic [AW-1:0] mk_addr(input logic [TAGW-1:0] tag, input int q, input int sub);
    return {tag, QW'(q), 2'(sub)};
  endfunction

  // One clock of stimulus; the model predicts the outcome and queues expectations.
  task automatic cycle(input logic rq, input logic rw, input logic [AW-1:0] addr,
                       input logic [DW-1:0] din, input logic [SRCW-1:0] src, input logic ackin,
                       input logic [NQ-1:0] ps, input logic [NQ-1:0] st, input logic rst);
    ring_t r;
    st_t s;
    logic hit, good;
    int q, sub;
    logic [NQ-1:0] clr_p, clr_s;
    @(negedge clk);
    if (release_pending) begin
      release dut.stall_cnt_q;
      release_pending = 1'b0;
    end
    reset = rst; reg_req_in = rq; reg_rd_wr_L_in = rw; reg_addr_in = addr;
    reg_data_in = din; reg_src_in = src; reg_ack_in = ackin; pkt_sent = ps; stall = st;

    hit  = (addr[AW-1:RAW] == TAG);
    q    = int'(addr[RAW-1:2]);
    sub  = int'(addr[1:0]);
    good = (q < int'(NQ));
    clr_p = '0;
    clr_s = '0;
    if (rst) begin
      for (int i = 0; i < int'(NQ); i++) begin
        en_m[i] = 1'b0; sh_m[i] = '0; pk_m[i] = '0; sl_m[i] = '0;
      end
      s.rst = 1'b1;
      s.req = 1'b0;
    end else begin
      if (rq && checking) begin
        r.addr = addr; r.src = src; r.rw = rw;
        if (hit) begin
          r.ack  = 1'b1;
          r.data = good ? rd_val(q, sub) : 32'hdead_beef;
        end else begin
          r.ack  = ackin;
          r.data = din;
        end
        ring_q.push_back(r);
      end
      if (rq && hit && good && !rw) begin
        case (sub)
          0:       en_m[q] = din[0];
          1:       sh_m[q] = din[SW-1:0];
          2:       clr_p[q] = 1'b1;
          default: clr_s[q] = 1'b1;
        endcase
      end
      for (int i = 0; i < int'(NQ); i++) begin
        pk_m[i] = bump(clr_p[i] ? 32'd0 : pk_m[i], ps[i]);
        sl_m[i] = bump(clr_s[i] ? 32'd0 : sl_m[i], st[i]);
      end
      s.rst = 1'b0;
      s.req = rq;
    end
    for (int i = 0; i < int'(NQ); i++) begin
      s.en[i]         = en_m[i];
      s.sh[i*SW +: SW] = sh_m[i];
    end
    if (checking) st_q.push_back(s);
  endtask

  task automatic idle(input logic [NQ-1:0] ps, input logic [NQ-1:0] st);
    cycle(1'b0, 1'b1, '0, '0, '0, 1'b0, ps, st, 1'b0);
  endtask

  task automatic reg_op(input logic rw, input int q, input int sub, input logic [DW-1:0] din,
                        input logic [NQ-1:0] ps);
    cycle(1'b1, rw, mk_addr(TAG, q, sub), din, SRCW'(q), 1'b0, ps, '0, 1'b0);
  endtask

  // Monitor: each cycle, compare DUT outputs against the oldest queued expectations.
  initial begin
    st_t s;
    ring_t r;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("req_out", 64'(reg_req_out), 64'(s.req));
        chk("enable_rate_limit", 64'(enable_rate_limit), 64'(s.en));
        chk("thruput_shift", 64'(thruput_shift), 64'(s.sh));
        if (s.rst) begin
          chk("ack_out_reset", 64'(reg_ack_out), 64'd0);
          chk("data_out_reset", 64'(reg_data_out), 64'd0);
        end
        if (reg_req_out === 1'b1) begin
          if (ring_q.size() == 0) begin
            chk("ring_unexpected", 64'd1, 64'd0);
          end else begin
            r = ring_q.pop_front();
            chk("ack_out", 64'(reg_ack_out), 64'(r.ack));
            chk("data_out", 64'(reg_data_out), 64'(r.data));
            chk("addr_out", 64'(reg_addr_out), 64'(r.addr));
            chk("src_out", 64'(reg_src_out), 64'(r.src));
            chk("rd_wr_L_out", 64'(reg_rd_wr_L_out), 64'(r.rw));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b1;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0; pkt_sent = '0; stall = '0;
    for (int i = 0; i < int'(NQ); i++) begin
      en_m[i] = 1'b0; sh_m[i] = '0; pk_m[i] = '0; sl_m[i] = '0;
    end
    checking = 1'b1;

    repeat (3) cycle(1'b0, 1'b1, '0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle('0, '0);

    // reset readback of queue 0 ENABLE
    reg_op(1'b1, 0, 0, '0, '0);
    idle('0, '0);

    // SHIFT write on queue 2, then read back
    reg_op(1'b0, 2, 1, 32'h5, '0);
    reg_op(1'b1, 2, 1, '0, '0);
    reg_op(1'b1, 1, 1, '0, '0);

    // packet counter on queue 1: seven pulses, read, clear with coincident pulse, read
    repeat (7) idle(NQ'(4'b0010), '0);
    reg_op(1'b1, 1, 2, '0, '0);
    reg_op(1'b0, 1, 2, 32'hffff_ffff, NQ'(4'b0010));
    reg_op(1'b1, 1, 2, '0, '0);
    // read coinciding with an increment returns the old value
    reg_op(1'b1, 1, 2, '0, NQ'(4'b0010));
    reg_op(1'b1, 1, 2, '0, '0);

    // stall counter on queue 3 preloaded near the top, then saturates
    idle('0, '0);
    sl_m[3] = 32'hFFFF_FFFE;
    for (int i = 0; i < int'(NQ); i++) force_val[i] = sl_m[i];
    force dut.stall_cnt_q = force_val;
    release_pending = 1'b1;
    repeat (5) idle(NQ'(4'b1000), '0 | NQ'(4'b1000));
    reg_op(1'b1, 3, 3, '0, '0);
    reg_op(1'b0, 3, 3, '0, '0);
    reg_op(1'b1, 3, 3, '0, '0);

    // out-of-range queue: read and write to q=4
    reg_op(1'b1, 4, 0, '0, '0);
    reg_op(1'b0, 4, 0, 32'hffff_ffff, '0);
    reg_op(1'b0, 4, 1, 32'hffff_ffff, '0);
    reg_op(1'b1, 0, 0, '0, '0);

    // tag miss passes through the ring unchanged
    cycle(1'b1, 1'b1, mk_addr(TAG ^ TAGW'(1), 0, 0), 32'h1234, 2'd2, 1'b1, '0, '0, 1'b0);
    idle('0, '0);

    // enable write, then reset in the middle of a transaction
    reg_op(1'b0, 1, 0, 32'h1, '0);
    cycle(1'b1, 1'b1, mk_addr(TAG, 1, 0), '0, 2'd1, 1'b0, '0, '0, 1'b1);
    idle('0, '0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [TAGW-1:0] tg;
      tg = ($urandom_range(0, 9) == 0) ? (TAG ^ TAGW'($urandom_range(1, 7))) : TAG;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            mk_addr(tg, int'($urandom_range(0, 5)), int'($urandom_range(0, 3))),
            DW'($urandom), SRCW'($urandom), 1'($urandom_range(0, 1)),
            NQ'($urandom) & NQ'($urandom), NQ'($urandom),
            1'($urandom_range(0, 299) == 0));
    end

    repeat (2) idle('0, '0);
    checking = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("ring_drain", 64'(ring_q.size()), 64'd0);
    chk("state_drain", 64'(st_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rate_limiter_multi_regs.md
Name: rate_limiter_multi_regs

Overview:
Per-queue register block for the multi-queue rate limiter. It sits in the UDP register ring and holds an enable bit and a throughput shift for each of NUM_QUEUES output queues. It also keeps two 32-bit statistics per queue, packets sent and stall cycles. Each statistic saturates and clears when written.

Parameters:
UDP_REG_SRC_WIDTH, 2, width of reg_src ring field
NUM_QUEUES, 4, number of rate-limited queues (1..16)
SHIFT_WIDTH, 4, width of each queue's throughput shift field
REG_ADDR_WIDTH, 6, block-local address width, `RATE_LIMIT_REG_ADDR_WIDTH in the top level
BLOCK_TAG, `RATE_LIMIT_0_BLOCK_ADDR, block tag matched against reg_addr_in[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH]

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
reg_req_in  in  1  ring request
reg_ack_in  in  1  ring ack
reg_rd_wr_L_in  in  1  1=read, 0=write
reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring address
reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring data
reg_src_in  in  UDP_REG_SRC_WIDTH  ring source
reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out  out  matching widths  registered ring outputs
pkt_sent  in  NUM_QUEUES  one-cycle pulse per packet released, one bit per queue
stall  in  NUM_QUEUES  level; queue i held back by its limiter this cycle
enable_rate_limit  out  NUM_QUEUES  per-queue enable
thruput_shift  out  NUM_QUEUES*SHIFT_WIDTH  queue i occupies bits [i*SHIFT_WIDTH +: SHIFT_WIDTH]

Behaviour:
- Clock and reset: clock clk; reset synchronous, active-high.
- Reset values:
  - req_out, ack_out, data_out = 0.
  - All enables, shifts and counters = 0.
  - rd_wr_L_out, addr_out and src_out are not reset; they always copy their inputs with 1-cycle delay.
- Address decode:
  - local = reg_addr_in[REG_ADDR_WIDTH-1:0].
  - q = local[REG_ADDR_WIDTH-1:2]; sub = local[1:0].
  - sub 0 = ENABLE (RW, bit 0).
  - sub 1 = SHIFT (RW, bits [SHIFT_WIDTH-1:0]).
  - sub 2 = PKT_COUNT (RO, write-to-clear).
  - sub 3 = STALL_COUNT (RO, write-to-clear).
  - tag_hit = upper address bits == BLOCK_TAG; addr_good = q < NUM_QUEUES.
- Request handling:
  - Fixed 1-cycle latency. req_out = req_in delayed 1 cycle, every cycle.
  - If req_in && tag_hit: ack_out <= 1 next cycle.
    - If addr_good, data_out <= the pre-update register value. RW fields read back zero-extended.
    - If addr_good and write: ENABLE/SHIFT load the low bits of reg_data_in; a write to a counter clears it (data ignored).
    - If !addr_good: data_out <= 32'hdead_beef and no state changes.
  - If !(req_in && tag_hit): ack_out <= ack_in and data_out <= data_in (pass-through).
- Counters:
  - PKT_COUNT[i] += 1 each cycle pkt_sent[i]=1. STALL_COUNT[i] += 1 each cycle stall[i]=1.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
  - All queues update in parallel.
- Boundary conditions:
  - Clear and increment in the same cycle: counter becomes 1. The read in that cycle returns the pre-clear value.
  - Read and increment in the same cycle: the read returns the old value; the counter updates.
  - Write to ENABLE/SHIFT: the output changes the cycle after the write.
  - Reset mid-transaction: ack_out and req_out drop to 0 the next cycle; the transaction is lost.
- Outputs enable_rate_limit and thruput_shift are driven directly from the register flops; no combinational path from ring inputs.

Test Plan:
- Reset, then read queue 0 ENABLE (local addr 0x00) -> ack 1 cycle later, data 0x0; enable_rate_limit = 0, thruput_shift = 0.
- Write 0x5 to queue 2 SHIFT (0x09), then read it back -> the following cycle thruput_shift[11:8] = 4'h5; readback 0x00000005; other queues unchanged.
- Pulse pkt_sent[1] 7 times, then read 0x06 -> data 7. Write 0x06 in the same cycle as a pkt_sent[1] pulse -> a subsequent read returns 1.
- Force STALL_COUNT[3] to 0xFFFF_FFFE and hold stall[3] high for 5 cycles -> reads 0xFFFF_FFFF (saturated, no wrap).
- With NUM_QUEUES=4, read 0x10 (q=4) -> ack, data 0xdead_beef; write 0x10 -> no register changes.
- Request with a non-matching tag, req_in=1, ack_in=1, data 0x1234 -> one cycle later req_out=1, ack_out=1, data_out=0x1234, addr and src unchanged.
